// File: rtl/audio_pkg.sv
// Shared types and constants for the AD1939 audio capture path.
package audio_pkg;

    localparam int DEFAULT_DATA_WIDTH = 24;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SHIFT,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with one-cycle rise/fall strobes.
module pin_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // level is taken from the edge-detect flop so every pin has identical latency
    assign level = dly_q;
    assign rise  = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/ad1939_adc_deserializer.sv
// AD1939 ADC serial receiver: oversampled I2S / left-justified capture into a
// one-pair valid/ready output buffer with sticky overflow and frame error strobe.
module ad1939_adc_deserializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int I2S_DELAY   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  ad1939_abclk,
    input  logic                  ad1939_alrclk,
    input  logic                  ad1939_asdata,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = (I2S_DELAY > 0) ? CNT_W'(I2S_DELAY - 1) : '0;
    localparam state_t START_ST = (I2S_DELAY == 0) ? ST_SHIFT : ST_DELAY;

    logic bclk_lvl, bclk_rise, bclk_fall;
    logic lrclk_lvl, lrclk_rise, lrclk_fall;
    logic data_lvl, data_rise, data_fall;
    logic lr_edge;

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(clk), .reset_n(reset_n), .pin(ad1939_abclk),
        .level(bclk_lvl), .rise(bclk_rise), .fall(bclk_fall)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk(clk), .reset_n(reset_n), .pin(ad1939_alrclk),
        .level(lrclk_lvl), .rise(lrclk_rise), .fall(lrclk_fall)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .reset_n(reset_n), .pin(ad1939_asdata),
        .level(data_lvl), .rise(data_rise), .fall(data_fall)
    );

    logic unused_pins;
    assign unused_pins = ^{bclk_lvl, bclk_fall, lrclk_lvl, data_rise, data_fall};

    assign lr_edge = lrclk_rise | lrclk_fall;

    state_t                state_q, state_d;
    logic                  ch_q, ch_d;
    logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic [DATA_WIDTH-1:0] shift_val;
    logic                  frame_err_d;
    logic                  pair_done;

    assign shift_val = {shreg_q[DATA_WIDTH-2:0], data_lvl};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ch_q        <= CH_LEFT;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            left_hold_q <= left_hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        left_hold_d = left_hold_q;
        frame_err_d = 1'b0;
        pair_done   = 1'b0;
        if (!enable) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lrclk_fall) begin
                        state_d  = START_ST;
                        ch_d     = CH_LEFT;
                        bitcnt_d = '0;
                    end
                end
                ST_DELAY: begin
                    if (lr_edge) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                        bitcnt_d    = '0;
                    end else if (bclk_rise) begin
                        if (bitcnt_q == DLY_LAST) begin
                            state_d  = ST_SHIFT;
                            bitcnt_d = '0;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (lr_edge) begin
                        // slot ended early: the whole pair is abandoned
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                        bitcnt_d    = '0;
                    end else if (bclk_rise) begin
                        shreg_d  = shift_val;
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q == LAST_BIT) begin
                            state_d = ST_WAIT;
                            if (ch_q == CH_LEFT) left_hold_d = shift_val;
                            else                 pair_done   = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    // bitcnt holds at DATA_WIDTH here; trailing slot bits are ignored
                    if ((ch_q == CH_LEFT && lrclk_rise) || (ch_q == CH_RIGHT && lrclk_fall)) begin
                        state_d  = START_ST;
                        ch_d     = ~ch_q;
                        bitcnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    logic load, drop;
    assign load = pair_done & (~sample_valid | sample_ready);
    assign drop = pair_done & ~load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            overflow     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_err <= frame_err_d;
            if (load) begin
                left_data    <= left_hold_q;
                right_data   <= shift_val;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            // a drop in the same cycle as a clear keeps the flag set
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ad1939_adc_deserializer.sv
// Directed bench: drives an AD1939-style serial stream into an I2S and a left-justified receiver.
module tb_ad1939_adc_deserializer;

    localparam int W  = 24;
    localparam int BH = 163;

    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic abclk = 1'b0, alrclk = 1'b1, asdata = 1'b0;
    logic ready0 = 1'b1, ready1 = 1'b1, ovclr = 1'b0;
    logic [W-1:0] ld0, rd0, ld1, rd1;
    logic sv0, sv1, ov0, ov1, fe0, fe1;

    int n_cmp = 0, n_bad = 0;
    int acc0_n = 0, acc1_n = 0, fe0_n = 0, fe_run = 0, fe_max = 0;
    logic [W-1:0] acc0_l = '0, acc0_r = '0, acc1_l = '0, acc1_r = '0;
    int a0, a1, f0;

    always #10 clk = ~clk;

    ad1939_adc_deserializer #(.DATA_WIDTH(W), .SYNC_STAGES(2), .I2S_DELAY(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .ad1939_abclk(abclk), .ad1939_alrclk(alrclk), .ad1939_asdata(asdata),
        .left_data(ld0), .right_data(rd0), .sample_valid(sv0), .sample_ready(ready0),
        .overflow(ov0), .overflow_clr(ovclr), .frame_err(fe0)
    );

    ad1939_adc_deserializer #(.DATA_WIDTH(W), .SYNC_STAGES(2), .I2S_DELAY(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .ad1939_abclk(abclk), .ad1939_alrclk(alrclk), .ad1939_asdata(asdata),
        .left_data(ld1), .right_data(rd1), .sample_valid(sv1), .sample_ready(ready1),
        .overflow(ov1), .overflow_clr(1'b0), .frame_err(fe1)
    );

    always @(negedge clk) begin
        if (sv0 && ready0) begin acc0_n++; acc0_l = ld0; acc0_r = rd0; end
        if (sv1 && ready1) begin acc1_n++; acc1_l = ld1; acc1_r = rd1; end
        if (fe0) begin fe0_n++; fe_run++; end else fe_run = 0;
        if (fe_run > fe_max) fe_max = fe_run;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic send_slot(input logic lr, input logic [W-1:0] d, input int nbits, input bit lj);
        for (int i = 0; i < nbits; i++) begin
            abclk = 1'b0;
            if (i == 0) alrclk = lr;
            asdata = 1'b0;
            if (lj && i < W)                 asdata = d[W-1-i];
            else if (!lj && i >= 1 && i <= W) asdata = d[W-i];
            #BH;
            abclk = 1'b1;
            #BH;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit lj);
        send_slot(1'b0, l, 32, lj);
        send_slot(1'b1, r, 32, lj);
    endtask

    task automatic snap();
        a0 = acc0_n; a1 = acc1_n; f0 = fe0_n;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_left",  32'(ld0), 32'h0);
        chk("rst_right", 32'(rd0), 32'h0);
        chk("rst_valid", 32'(sv0), 32'h0);
        chk("rst_ovf",   32'(ov0), 32'h0);
        chk("rst_ferr",  32'(fe0), 32'h0);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (5) @(posedge clk);

        // 1: I2S frame
        snap();
        send_frame(24'h123456, 24'hFEDCBA, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t1_count", 32'(acc0_n - a0), 32'd1);
        chk("t1_left",  32'(acc0_l), 32'h123456);
        chk("t1_right", 32'(acc0_r), 32'hFEDCBA);
        chk("t1_ovf",   32'(ov0), 32'h0);
        chk("t1_ferr",  32'(fe0_n - f0), 32'd0);
        chk("t1_lj_count", 32'(acc1_n - a1), 32'd1);
        chk("t1_lj_left",  32'(acc1_l), 32'h091A2B);
        chk("t1_lj_right", 32'(acc1_r), 32'h7F6E5D);

        // 2: left-justified frame
        snap();
        send_frame(24'h123456, 24'hFEDCBA, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("t2_lj_count", 32'(acc1_n - a1), 32'd1);
        chk("t2_lj_left",  32'(acc1_l), 32'h123456);
        chk("t2_lj_right", 32'(acc1_r), 32'hFEDCBA);
        chk("t2_i2s_left",  32'(acc0_l), 32'h2468AC);
        chk("t2_i2s_right", 32'(acc0_r), 32'hFDB974);

        // 3: backpressure across two frames
        snap();
        ready0 = 1'b0;
        send_frame(24'h111111, 24'h222222, 1'b0);
        send_frame(24'h333333, 24'h444444, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t3_valid", 32'(sv0), 32'h1);
        chk("t3_left",  32'(ld0), 32'h111111);
        chk("t3_right", 32'(rd0), 32'h222222);
        chk("t3_ovf",   32'(ov0), 32'h1);
        ovclr = 1'b1;
        @(posedge clk); #1;
        ovclr = 1'b0;
        chk("t3_ovf_clr", 32'(ov0), 32'h0);
        ready0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t3_count", 32'(acc0_n - a0), 32'd1);
        chk("t3_acc_left",  32'(acc0_l), 32'h111111);
        chk("t3_acc_right", 32'(acc0_r), 32'h222222);
        chk("t3_valid_off", 32'(sv0), 32'h0);

        // 4: short left slot
        snap();
        send_slot(1'b0, 24'h555555, 10, 1'b0);
        send_slot(1'b1, 24'h666666, 32, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("t4_ferr_count", 32'(fe0_n - f0), 32'd1);
        chk("t4_no_valid",   32'(acc0_n - a0), 32'd0);
        send_frame(24'h777777, 24'h888888, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t4_count", 32'(acc0_n - a0), 32'd1);
        chk("t4_left",  32'(acc0_l), 32'h777777);
        chk("t4_right", 32'(acc0_r), 32'h888888);
        chk("t4_ferr_width", 32'(fe_max), 32'd1);

        // 5: enable dropped mid right channel
        snap();
        fork
            send_frame(24'h121212, 24'h343434, 1'b0);
            begin #(BH * 2 * (32 + 12)); enable = 1'b0; end
        join
        send_frame(24'h565656, 24'h787878, 1'b0);
        send_frame(24'h9A9A9A, 24'hBCBCBC, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_partial", 32'(acc0_n - a0), 32'd0);
        enable = 1'b1;
        send_frame(24'h999999, 24'hAAAAAA, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_count", 32'(acc0_n - a0), 32'd1);
        chk("t5_left",  32'(acc0_l), 32'h999999);
        chk("t5_right", 32'(acc0_r), 32'hAAAAAA);
        chk("t5_ferr",  32'(fe0_n - f0), 32'd0);

        // 6: async reset mid-shift
        fork
            send_frame(24'hBBBBBB, 24'hCCCCCC, 1'b0);
            begin
                #(BH * 2 * 10);
                reset_n = 1'b0;
                #1;
                chk("t6_left",  32'(ld0), 32'h0);
                chk("t6_right", 32'(rd0), 32'h0);
                chk("t6_valid", 32'(sv0), 32'h0);
                #100;
                reset_n = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        snap();
        send_frame(24'hDDDDDD, 24'hEEEEEE, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t6_count", 32'(acc0_n - a0), 32'd1);
        chk("t6_acc_left",  32'(acc0_l), 32'hDDDDDD);
        chk("t6_acc_right", 32'(acc0_r), 32'hEEEEEE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
